// File: rtl/icosoc_spi_slave_fifo_pkg.sv
// Shared constants and types for the SPI slave word-buffering stage:
// register map, status/control bit positions and the bus decode types.
package icosoc_spi_slave_fifo_pkg;

    localparam logic [7:0] ADDR_STATUS = 8'h00;
    localparam logic [7:0] ADDR_TXDATA = 8'h04;
    localparam logic [7:0] ADDR_RXDATA = 8'h08;
    localparam logic [7:0] ADDR_CTRL   = 8'h0C;

    localparam int ST_RX_CNT_LSB = 0;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_OVF     = 16;
    localparam int ST_TX_UNF     = 17;
    localparam int ST_TX_OVF     = 18;

    localparam int CTRL_FLUSH_RX  = 0;
    localparam int CTRL_FLUSH_TX  = 1;
    localparam int CTRL_CLR_FLAGS = 2;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_READ,
        BUS_WRITE
    } bus_op_e;

    typedef struct packed {
        logic tx_ovf;
        logic tx_unf;
        logic rx_ovf;
    } flags_t;

    function automatic logic [31:0] pack_status(
        input logic [7:0] rx_cnt,
        input logic [7:0] tx_cnt,
        input flags_t     f
    );
        logic [31:0] s;
        s = '0;
        s[ST_RX_CNT_LSB +: 8] = rx_cnt;
        s[ST_TX_CNT_LSB +: 8] = tx_cnt;
        s[ST_RX_OVF]          = f.rx_ovf;
        s[ST_TX_UNF]          = f.tx_unf;
        s[ST_TX_OVF]          = f.tx_ovf;
        return s;
    endfunction

endpackage

// File: rtl/icosoc_sync_fifo32.sv
// 32-bit synchronous FIFO with a registered first-word-fall-through head.
// Flush wins over push/pop; a push alongside a pop is accepted when full.
module icosoc_sync_fifo32 #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [31:0]              din,
    output logic [31:0]              dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_after_pop;
    logic [31:0]   head_q, head_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign dout  = head_q;
    assign count = cnt_q;

    // Next pointers, count and head; head bypasses din when the FIFO
    // would otherwise be empty so the word shows one edge after push.
    always_comb begin
        do_pop        = pop & ~empty & ~flush;
        do_push       = push & (~full | do_pop) & ~flush;
        wr_d          = wr_q;
        rd_d          = rd_q;
        cnt_d         = cnt_q;
        head_d        = head_q;
        cnt_after_pop = cnt_q - CW'(do_pop);
        if (flush) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            head_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_after_pop + CW'(do_push);
            if (cnt_d == '0) begin
                head_d = '0;
            end else if (cnt_after_pop == '0) begin
                head_d = din;
            end else begin
                head_d = mem_q[rd_d];
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/icosoc_spi_slave_fifo.sv
// SPI slave TX/RX word buffers behind the icosoc ctrl register window,
// with sticky error flags and a level interrupt.
module icosoc_spi_slave_fifo
    import icosoc_spi_slave_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int RX_THRESH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_wr,
    input  logic        ctrl_rd,
    input  logic [7:0]  ctrl_addr,
    input  logic [31:0] ctrl_wdat,
    output logic [31:0] ctrl_rdat,
    output logic        ctrl_done,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    input  logic        tx_req,
    output logic [31:0] tx_data,
    output logic        tx_empty,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THRESH = CW'(RX_THRESH);

    bus_op_e       op;
    logic          done_q, done_d;
    logic [31:0]   rdat_q, rdat_d;
    flags_t        flg_q, flg_d;
    logic          irq_q, irq_d;

    logic          tx_push, rx_pop, ctl_wr;
    logic          flush_rx, flush_tx, clr_flags;

    logic [31:0]   rx_dout, tx_dout;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic          rx_full, rx_empty, tx_full, tx_empty_w;

    icosoc_sync_fifo32 #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (rx_pop),
        .flush (flush_rx),
        .din   (rx_data),
        .dout  (rx_dout),
        .count (rx_cnt),
        .full  (rx_full),
        .empty (rx_empty)
    );

    icosoc_sync_fifo32 #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_req),
        .flush (flush_tx),
        .din   (ctrl_wdat),
        .dout  (tx_dout),
        .count (tx_cnt),
        .full  (tx_full),
        .empty (tx_empty_w)
    );

    // Accept a request only while no acknowledge is outstanding; read wins.
    always_comb begin
        op = BUS_IDLE;
        if (!done_q) begin
            if (ctrl_rd)      op = BUS_READ;
            else if (ctrl_wr) op = BUS_WRITE;
        end
    end

    // Address decode into FIFO and control strobes.
    always_comb begin
        tx_push   = 1'b0;
        rx_pop    = 1'b0;
        ctl_wr    = 1'b0;
        if (op == BUS_WRITE) begin
            tx_push = (ctrl_addr == ADDR_TXDATA);
            ctl_wr  = (ctrl_addr == ADDR_CTRL);
        end
        if (op == BUS_READ) begin
            rx_pop  = (ctrl_addr == ADDR_RXDATA);
        end
        flush_rx  = ctl_wr & ctrl_wdat[CTRL_FLUSH_RX];
        flush_tx  = ctl_wr & ctrl_wdat[CTRL_FLUSH_TX];
        clr_flags = ctl_wr & ctrl_wdat[CTRL_CLR_FLAGS];
    end

    // Read data mux, captured on the accept edge.
    always_comb begin
        rdat_d = '0;
        if (op == BUS_READ) begin
            case (ctrl_addr)
                ADDR_STATUS: rdat_d = pack_status(8'(rx_cnt), 8'(tx_cnt), flg_q);
                ADDR_TXDATA: rdat_d = tx_dout;
                ADDR_RXDATA: rdat_d = rx_dout;
                default:     rdat_d = '0;
            endcase
        end
        done_d = (op != BUS_IDLE);
    end

    // Sticky flags; a flush suppresses its FIFO's flag, clear beats set.
    always_comb begin
        flg_d = flg_q;
        if (rx_valid & rx_full & ~rx_pop & ~flush_rx)   flg_d.rx_ovf = 1'b1;
        if (tx_req & tx_empty_w & ~flush_tx)            flg_d.tx_unf = 1'b1;
        if (tx_push & tx_full & ~tx_req & ~flush_tx)    flg_d.tx_ovf = 1'b1;
        if (clr_flags) flg_d = '0;
        irq_d = (rx_cnt >= THRESH) | flg_q.rx_ovf | flg_q.tx_unf | flg_q.tx_ovf;
    end

    // Handshake, read data, flag and interrupt registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            rdat_q <= '0;
            flg_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            rdat_q <= rdat_d;
            flg_q  <= flg_d;
            irq_q  <= irq_d;
        end
    end

    assign ctrl_done = done_q;
    assign ctrl_rdat = rdat_q;
    assign tx_data   = tx_dout;
    assign tx_empty  = tx_empty_w;
    assign irq       = irq_q;

endmodule

// File: tb/tb_icosoc_spi_slave_fifo.sv
// Self-checking bench for icosoc_spi_slave_fifo: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_icosoc_spi_slave_fifo;

    localparam int DEPTH  = 16;
    localparam int THRESH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_wr, ctrl_rd;
    logic [7:0]  ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        tx_req;
    logic [31:0] tx_data;
    logic        tx_empty;
    logic        irq;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] rxq[$];
    logic [31:0] txq[$];
    bit          m_rxo, m_txu, m_txo;
    bit          m_done, m_irq;
    logic [31:0] m_rdat;

    icosoc_spi_slave_fifo #(.DEPTH(DEPTH), .RX_THRESH(THRESH)) dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl_wr   (ctrl_wr),
        .ctrl_rd   (ctrl_rd),
        .ctrl_addr (ctrl_addr),
        .ctrl_wdat (ctrl_wdat),
        .ctrl_rdat (ctrl_rdat),
        .ctrl_done (ctrl_done),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .tx_empty  (tx_empty),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_rxo = 0; m_txu = 0; m_txo = 0;
        m_done = 0; m_irq = 0; m_rdat = '0;
    endtask

    // One clock edge of the block, expressed as queue operations.
    task automatic model_cycle(input bit rv, input logic [31:0] rxd, input bit tr,
                               input bit wr, input bit rd, input logic [7:0] a,
                               input logic [31:0] wd);
        bit samp, isrd, iswr, prx, ptx, frx, ftx, clr, nirq;
        logic [31:0] r;
        nirq = (rxq.size() >= THRESH) || m_rxo || m_txu || m_txo;
        samp = (wr || rd) && !m_done;
        isrd = samp && rd;
        iswr = samp && wr && !rd;
        r = '0;
        prx = 0;
        if (isrd) begin
            if (a == 8'h00)
                r = {13'd0, m_txo, m_txu, m_rxo, 8'(txq.size()), 8'(rxq.size())};
            else if (a == 8'h04)
                r = (txq.size() > 0) ? txq[0] : 32'd0;
            else if (a == 8'h08 && rxq.size() > 0) begin
                r = rxq[0];
                prx = 1;
            end
        end
        ptx = iswr && (a == 8'h04);
        frx = iswr && (a == 8'h0C) && wd[0];
        ftx = iswr && (a == 8'h0C) && wd[1];
        clr = iswr && (a == 8'h0C) && wd[2];
        if (frx) rxq.delete();
        else begin
            if (prx) rxq.delete(0);
            if (rv) begin
                if (rxq.size() < DEPTH) rxq.push_back(rxd);
                else m_rxo = 1;
            end
        end
        if (ftx) txq.delete();
        else begin
            if (tr) begin
                if (txq.size() > 0) txq.delete(0);
                else m_txu = 1;
            end
            if (ptx) begin
                if (txq.size() < DEPTH) txq.push_back(wd);
                else m_txo = 1;
            end
        end
        if (clr) begin
            m_rxo = 0; m_txu = 0; m_txo = 0;
        end
        m_done = samp;
        m_rdat = r;
        m_irq  = nirq;
    endtask

    // Drive one cycle of inputs (called just after a falling edge).
    task automatic step(input bit rv, input logic [31:0] rxd, input bit tr,
                        input bit wr, input bit rd, input logic [7:0] a,
                        input logic [31:0] wd);
        rx_valid  = rv;
        rx_data   = rxd;
        tx_req    = tr;
        ctrl_wr   = wr;
        ctrl_rd   = rd;
        ctrl_addr = a;
        ctrl_wdat = wd;
        model_cycle(rv, rxd, tr, wr, rd, a, wd);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0, 8'h00, '0);
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d, output logic dn);
        step(0, '0, 0, 0, 1, a, '0);
        d  = ctrl_rdat;
        dn = ctrl_done;
        idle();
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] wd);
        step(0, '0, 0, 1, 0, a, wd);
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic dn;
        reset = 1;
        rx_valid = 0; rx_data = '0; tx_req = 0;
        ctrl_wr = 0; ctrl_rd = 0; ctrl_addr = '0; ctrl_wdat = '0;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({ctrl_done, ctrl_rdat, tx_data, tx_empty, irq} !== {1'b0, 32'd0, 32'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got done=%b rdat=%h txd=%h txe=%b irq=%b want 0/0/0/1/0",
                     ctrl_done, ctrl_rdat, tx_data, tx_empty, irq);
        end
        reset = 0;
        @(negedge clk);
        step(0, '0, 0, 0, 1, 8'h00, '0);
        d = ctrl_rdat;
        dn = ctrl_done;
        total++;
        if (dn !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL reset_status: got done=%b rdat=%h want 1/00000000", dn, d);
        end
        idle();
        total++;
        if (ctrl_done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle: got done=%b want 0", ctrl_done);
        end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        logic dn;
        step(0, '0, 0, 1, 0, 8'h04, 32'hA5A5A5A5);
        total++;
        if (tx_data !== 32'hA5A5A5A5 || tx_empty !== 1'b0) begin
            bad++;
            $display("FAIL tx_fwft: got txd=%h txe=%b want a5a5a5a5/0", tx_data, tx_empty);
        end
        idle();
        bus_wr(8'h04, 32'h12345678);
        bus_rd(8'h00, d, dn);
        total++;
        if (d !== 32'h00000200) begin
            bad++;
            $display("FAIL tx_count2: got %h want 00000200", d);
        end
        step(0, '0, 1, 0, 0, 8'h00, '0);
        total++;
        if (tx_data !== 32'h12345678) begin
            bad++;
            $display("FAIL tx_pop1: got %h want 12345678", tx_data);
        end
        step(0, '0, 1, 0, 0, 8'h00, '0);
        total++;
        if (tx_data !== 32'h0 || tx_empty !== 1'b1) begin
            bad++;
            $display("FAIL tx_pop2: got txd=%h txe=%b want 0/1", tx_data, tx_empty);
        end
        step(0, '0, 1, 0, 0, 8'h00, '0);
        bus_rd(8'h00, d, dn);
        total++;
        if (d !== 32'h00020000 || irq !== 1'b1) begin
            bad++;
            $display("FAIL tx_underflow: got status=%h irq=%b want 00020000/1", d, irq);
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        logic dn;
        bus_wr(8'h0C, 32'h4);
        for (int i = 1; i <= DEPTH + 1; i++) bus_wr(8'h04, 32'(i));
        bus_rd(8'h00, d, dn);
        total++;
        if (d !== 32'h00041000) begin
            bad++;
            $display("FAIL tx_overflow: got %h want 00041000", d);
        end
        bus_rd(8'h04, d, dn);
        total++;
        if (d !== 32'h1 || tx_data !== 32'h1) begin
            bad++;
            $display("FAIL tx_peek: got rdat=%h txd=%h want 1/1", d, tx_data);
        end
        bus_wr(8'h0C, 32'h6);
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d;
        logic dn;
        for (int i = 1; i <= DEPTH + 1; i++) step(1, 32'(i), 0, 0, 0, 8'h00, '0);
        bus_rd(8'h00, d, dn);
        total++;
        if (d !== 32'h00010010 || irq !== 1'b1) begin
            bad++;
            $display("FAIL rx_overflow: got status=%h irq=%b want 00010010/1", d, irq);
        end
        for (int i = 1; i <= DEPTH + 1; i++) begin
            bus_rd(8'h08, d, dn);
            total++;
            if (d !== ((i <= DEPTH) ? 32'(i) : 32'd0)) begin
                bad++;
                $display("FAIL rx_pop_%0d: got %h want %h", i, d,
                         (i <= DEPTH) ? 32'(i) : 32'd0);
            end
        end
    endtask

    task automatic test_rx_full_pop_push();
        logic [31:0] d;
        logic dn;
        bus_wr(8'h0C, 32'h4);
        for (int i = 0; i < DEPTH; i++) step(1, 32'h100 + 32'(i), 0, 0, 0, 8'h00, '0);
        step(1, 32'hBEEF, 0, 0, 1, 8'h08, '0);
        total++;
        if (ctrl_rdat !== 32'h100) begin
            bad++;
            $display("FAIL full_pop_push_data: got %h want 00000100", ctrl_rdat);
        end
        idle();
        bus_rd(8'h00, d, dn);
        total++;
        if (d !== 32'h00000010) begin
            bad++;
            $display("FAIL full_pop_push_status: got %h want 00000010", d);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        logic dn;
        bus_wr(8'h04, 32'h55);
        step(1, 32'hDEAD, 0, 0, 0, 8'h00, '0);
        step(1, 32'hCAFE, 0, 1, 0, 8'h0C, 32'h7);
        idle();
        bus_rd(8'h00, d, dn);
        total++;
        if (d !== 32'h0 || irq !== 1'b0 || tx_empty !== 1'b1) begin
            bad++;
            $display("FAIL flush_all: got status=%h irq=%b txe=%b want 0/0/1", d, irq, tx_empty);
        end
    endtask

    task automatic test_thresh();
        logic [31:0] d;
        logic dn;
        for (int i = 0; i < THRESH - 1; i++) step(1, 32'h200 + 32'(i), 0, 0, 0, 8'h00, '0);
        idle();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL thresh_below: got irq=%b want 0", irq);
        end
        step(1, 32'h2FF, 0, 0, 0, 8'h00, '0);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL thresh_latency: got irq=%b want 0", irq);
        end
        idle();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL thresh_reach: got irq=%b want 1", irq);
        end
        bus_rd(8'h08, d, dn);
        total++;
        if (irq !== 1'b0 || d !== 32'h200) begin
            bad++;
            $display("FAIL thresh_drop: got irq=%b rdat=%h want 0/00000200", irq, d);
        end
        repeat (THRESH - 1) bus_rd(8'h08, d, dn);
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [5];
        logic [7:0] a;
        logic [31:0] wd, exp_tx;
        bit rv, tr, wr, rd;
        int sel;
        addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08;
        addrs[3] = 8'h0C; addrs[4] = 8'h10;
        for (int n = 0; n < 600; n++) begin
            rv  = ($urandom_range(0, 99) < 45);
            tr  = ($urandom_range(0, 99) < 30);
            wr  = ($urandom_range(0, 99) < 50);
            rd  = ($urandom_range(0, 99) < 40);
            sel = $urandom_range(0, 4);
            a   = addrs[sel];
            wd  = $urandom;
            if (a == 8'h0C && $urandom_range(0, 3) != 0) wd[2:0] = 3'b000;
            step(rv, $urandom, tr, wr, rd, a, wd);
            exp_tx = (txq.size() > 0) ? txq[0] : 32'd0;
            total++;
            if (ctrl_done !== m_done || ctrl_rdat !== m_rdat || tx_data !== exp_tx ||
                tx_empty !== (txq.size() == 0) || irq !== m_irq) begin
                bad++;
                $display("FAIL rand_%0d: got done=%b rdat=%h txd=%h txe=%b irq=%b want %b/%h/%h/%b/%b",
                         n, ctrl_done, ctrl_rdat, tx_data, tx_empty, irq,
                         m_done, m_rdat, exp_tx, txq.size() == 0, m_irq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_overflow();
        test_rx_overflow();
        test_rx_full_pop_push();
        test_flush();
        test_thresh();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
